// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared types and default sizes for the reorder buffer slice.
//   - rob_entry_t    : one ring slot (valid/completed/branch/mispred/target/
//                      tag/told)
//   - rob_dis_lane_t : one dispatch lane packet as seen by the ring
//   - rob_ret_lane_t : one retire lane packet driven to the arch map/free list
// The entry struct is sized by ROB_TAG_W/ROB_XLEN, so any rob_ring instance
// must keep TAG_W/XLEN equal to these widths.
// ---------------------------------------------------------------------------
package rob_pkg;

  localparam int ROB_N_WAY = 2;
  localparam int ROB_N_ROB = 32;
  localparam int ROB_TAG_W = 6;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_IDX_W = $clog2(ROB_N_ROB);

  typedef struct packed {
    logic                 valid;
    logic                 completed;
    logic                 branch;
    logic                 mispred;
    logic [ROB_XLEN-1:0]  target;
    logic [ROB_TAG_W-1:0] tag;
    logic [ROB_TAG_W-1:0] told;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 branch;
    logic [ROB_TAG_W-1:0] tag;
    logic [ROB_TAG_W-1:0] told;
  } rob_dis_lane_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic                 told_valid;
    logic [ROB_TAG_W-1:0] told;
  } rob_ret_lane_t;

  // Fresh entry as written by dispatch: valid, not yet completed.
  function automatic rob_entry_t rob_new_entry(input rob_dis_lane_t lane);
    rob_entry_t e;
    e           = '0;
    e.valid     = 1'b1;
    e.branch    = lane.branch;
    e.tag       = lane.tag;
    e.told      = lane.told;
    return e;
  endfunction

endpackage

// File: rtl/rob_tag_cam.sv
// ---------------------------------------------------------------------------
// rob_tag_cam
// Compares every CDB lane against every ring slot's tag and reports which
// slots complete this cycle, plus the mispredict flag/target to latch.
// Ports:
//   enable        in   completion allowed this cycle (low during flush)
//   entry_valid   in   per-slot valid
//   entry_tag     in   per-slot tag, slot s at [s*TAG_W +: TAG_W]
//   cmp_valid     in   CDB lane valid
//   cmp_tag       in   CDB lane tag
//   cmp_mispred   in   CDB lane mispredict flag
//   cmp_target    in   CDB lane redirect target
//   hit           out  slot is completed by some lane
//   hit_mispred   out  mispredict flag of the matching lane
//   hit_target    out  target of the matching lane, slot s at [s*XLEN +: XLEN]
// ---------------------------------------------------------------------------
module rob_tag_cam
  import rob_pkg::*;
#(
  parameter int               N_WAY    = ROB_N_WAY,
  parameter int               N_ROB    = ROB_N_ROB,
  parameter int               TAG_W    = ROB_TAG_W,
  parameter int               XLEN     = ROB_XLEN,
  parameter logic [TAG_W-1:0] ZERO_TAG = '0
) (
  input  logic                    enable,
  input  logic [N_ROB-1:0]        entry_valid,
  input  logic [N_ROB*TAG_W-1:0]  entry_tag,
  input  logic [N_WAY-1:0]        cmp_valid,
  input  logic [N_WAY*TAG_W-1:0]  cmp_tag,
  input  logic [N_WAY-1:0]        cmp_mispred,
  input  logic [N_WAY*XLEN-1:0]   cmp_target,
  output logic [N_ROB-1:0]        hit,
  output logic [N_ROB-1:0]        hit_mispred,
  output logic [N_ROB*XLEN-1:0]   hit_target
);

  // The x0 tag is never a real producer, so it never matches.
  always_comb begin
    hit         = '0;
    hit_mispred = '0;
    hit_target  = '0;
    for (int s = 0; s < N_ROB; s++) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (enable && cmp_valid[w] && entry_valid[s] &&
            (cmp_tag[w*TAG_W +: TAG_W] != ZERO_TAG) &&
            (entry_tag[s*TAG_W +: TAG_W] == cmp_tag[w*TAG_W +: TAG_W])) begin
          hit[s]                     = 1'b1;
          hit_mispred[s]             = cmp_mispred[w];
          hit_target[s*XLEN +: XLEN] = cmp_target[w*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// ---------------------------------------------------------------------------
// rob_ring
// Circular reorder buffer with binary head/tail pointers and an occupancy
// counter. Dispatches, completes and retires up to N_WAY entries per cycle;
// a mispredicted branch retiring at head flushes everything younger.
// Ports:
//   clock, reset                 clock and async active-low reset
//   dis_valid/tag/told/branch    dispatch lanes (prefix from lane 0)
//   dis_ready                    lane accepted this cycle
//   cmp_valid/tag/mispred/target CDB completion lanes
//   ret_valid/tag                retiring entries, oldest first
//   ret_told_valid/ret_told      previous mapping to return to the free list
//   flush/flush_pc               mispredict redirect
//   squash_valid/squash_tag      younger tags dropped by the flush, per slot
//   free_slots                   free entries at the start of the cycle
// ---------------------------------------------------------------------------
module rob_ring
  import rob_pkg::*;
#(
  parameter int               N_WAY    = ROB_N_WAY,
  parameter int               N_ROB    = ROB_N_ROB,
  parameter int               TAG_W    = ROB_TAG_W,
  parameter int               XLEN     = ROB_XLEN,
  parameter logic [TAG_W-1:0] ZERO_TAG = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WAY-1:0]            dis_valid,
  input  logic [N_WAY*TAG_W-1:0]      dis_tag,
  input  logic [N_WAY*TAG_W-1:0]      dis_told,
  input  logic [N_WAY-1:0]            dis_branch,
  output logic [N_WAY-1:0]            dis_ready,
  input  logic [N_WAY-1:0]            cmp_valid,
  input  logic [N_WAY*TAG_W-1:0]      cmp_tag,
  input  logic [N_WAY-1:0]            cmp_mispred,
  input  logic [N_WAY*XLEN-1:0]       cmp_target,
  output logic [N_WAY-1:0]            ret_valid,
  output logic [N_WAY*TAG_W-1:0]      ret_tag,
  output logic [N_WAY-1:0]            ret_told_valid,
  output logic [N_WAY*TAG_W-1:0]      ret_told,
  output logic                        flush,
  output logic [XLEN-1:0]             flush_pc,
  output logic [N_ROB-1:0]            squash_valid,
  output logic [N_ROB*TAG_W-1:0]      squash_tag,
  output logic [$clog2(N_ROB):0]      free_slots
);

  localparam int IDX_W = $clog2(N_ROB);
  localparam int CNT_W = IDX_W + 1;

  rob_entry_t       entries_q [N_ROB];
  rob_entry_t       entries_d [N_ROB];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  rob_dis_lane_t    dis_lane [N_WAY];
  rob_ret_lane_t    ret_lane [N_WAY];
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [N_ROB-1:0] retire_slot;
  logic             flush_hit;
  logic [XLEN-1:0]  flush_target;

  logic [N_ROB-1:0]       cam_valid;
  logic [N_ROB*TAG_W-1:0] cam_tag;
  logic [N_ROB-1:0]       cam_hit;
  logic [N_ROB-1:0]       cam_mispred;
  logic [N_ROB*XLEN-1:0]  cam_target;

  assign free_slots = CNT_W'(N_ROB) - count_q;

  always_comb begin
    cam_valid = '0;
    cam_tag   = '0;
    for (int s = 0; s < N_ROB; s++) begin
      cam_valid[s]                = entries_q[s].valid;
      cam_tag[s*TAG_W +: TAG_W]   = entries_q[s].tag;
    end
  end

  rob_tag_cam #(
    .N_WAY    (N_WAY),
    .N_ROB    (N_ROB),
    .TAG_W    (TAG_W),
    .XLEN     (XLEN),
    .ZERO_TAG (ZERO_TAG)
  ) u_cam (
    .enable      (!flush_hit),
    .entry_valid (cam_valid),
    .entry_tag   (cam_tag),
    .cmp_valid   (cmp_valid),
    .cmp_tag     (cmp_tag),
    .cmp_mispred (cmp_mispred),
    .cmp_target  (cmp_target),
    .hit         (cam_hit),
    .hit_mispred (cam_mispred),
    .hit_target  (cam_target)
  );

  // Retire walks head, head+1, ... and stops at the first entry that is not
  // ready or right after a mispredicted branch, which ends the retire group.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             chain;
    idx          = '0;
    chain        = 1'b1;
    ret_cnt      = '0;
    retire_slot  = '0;
    flush_hit    = 1'b0;
    flush_target = '0;
    for (int i = 0; i < N_WAY; i++) begin
      idx         = head_q + IDX_W'(i);
      ret_lane[i] = '0;
      if (chain && entries_q[idx].valid && entries_q[idx].completed) begin
        ret_lane[i].valid      = 1'b1;
        ret_lane[i].tag        = entries_q[idx].tag;
        ret_lane[i].told       = entries_q[idx].told;
        ret_lane[i].told_valid = (entries_q[idx].told != ZERO_TAG);
        retire_slot[idx]       = 1'b1;
        ret_cnt                = ret_cnt + CNT_W'(1);
        if (entries_q[idx].branch && entries_q[idx].mispred) begin
          flush_hit    = 1'b1;
          flush_target = entries_q[idx].target;
          chain        = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    ret_valid      = '0;
    ret_tag        = '0;
    ret_told_valid = '0;
    ret_told       = '0;
    for (int i = 0; i < N_WAY; i++) begin
      ret_valid[i]                 = ret_lane[i].valid;
      ret_tag[i*TAG_W +: TAG_W]    = ret_lane[i].tag;
      ret_told_valid[i]            = ret_lane[i].told_valid;
      ret_told[i*TAG_W +: TAG_W]   = ret_lane[i].told;
    end
  end

  // Everything still valid that does not retire this cycle is younger than
  // the mispredicted branch, so it is all squashed.
  always_comb begin
    flush        = flush_hit;
    flush_pc     = flush_target;
    squash_valid = '0;
    squash_tag   = '0;
    for (int s = 0; s < N_ROB; s++) begin
      if (flush_hit && entries_q[s].valid && !retire_slot[s]) begin
        squash_valid[s]              = 1'b1;
        squash_tag[s*TAG_W +: TAG_W] = entries_q[s].tag;
      end
    end
  end

  // Acceptance looks only at the registered free count, so slots freed by
  // this cycle's retire are not reused until next cycle.
  always_comb begin
    acc_cnt   = '0;
    dis_ready = '0;
    for (int k = 0; k < N_WAY; k++) begin
      dis_lane[k].valid  = dis_valid[k];
      dis_lane[k].branch = dis_branch[k];
      dis_lane[k].tag    = dis_tag[k*TAG_W +: TAG_W];
      dis_lane[k].told   = dis_told[k*TAG_W +: TAG_W];
      if (dis_valid[k] && (CNT_W'(k) < free_slots) && !flush_hit) begin
        dis_ready[k] = 1'b1;
        acc_cnt      = acc_cnt + CNT_W'(1);
      end
    end
  end

  // Entry, pointer and count update. Completion is applied first; retire and
  // dispatch touch disjoint slots, and a flush overrides all of it.
  always_comb begin
    entries_d = entries_q;
    for (int s = 0; s < N_ROB; s++) begin
      if (cam_hit[s]) begin
        entries_d[s].completed = 1'b1;
        if (entries_q[s].branch) begin
          entries_d[s].mispred = cam_mispred[s];
          entries_d[s].target  = cam_target[s*XLEN +: XLEN];
        end
      end
      if (retire_slot[s]) begin
        entries_d[s] = '0;
      end
    end
    for (int k = 0; k < N_WAY; k++) begin
      if (dis_ready[k]) begin
        entries_d[tail_q + IDX_W'(k)] = rob_new_entry(dis_lane[k]);
      end
    end
    head_d  = head_q + IDX_W'(ret_cnt);
    tail_d  = tail_q + IDX_W'(acc_cnt);
    count_d = count_q + acc_cnt - ret_cnt;
    if (flush_hit) begin
      for (int s = 0; s < N_ROB; s++) begin
        entries_d[s] = '0;
      end
      tail_d  = head_d;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_ROB; s++) begin
        entries_q[s] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// ---------------------------------------------------------------------------
// tb_rob_ring
// Directed bench for rob_ring: in-order retire, full/hold, pointer wrap,
// mispredict flush with squash, and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_rob_ring;

  localparam int N_WAY = 2;
  localparam int N_ROB = 32;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  logic                   clock;
  logic                   reset;
  logic [N_WAY-1:0]       dis_valid;
  logic [N_WAY*TAG_W-1:0] dis_tag;
  logic [N_WAY*TAG_W-1:0] dis_told;
  logic [N_WAY-1:0]       dis_branch;
  logic [N_WAY-1:0]       dis_ready;
  logic [N_WAY-1:0]       cmp_valid;
  logic [N_WAY*TAG_W-1:0] cmp_tag;
  logic [N_WAY-1:0]       cmp_mispred;
  logic [N_WAY*XLEN-1:0]  cmp_target;
  logic [N_WAY-1:0]       ret_valid;
  logic [N_WAY*TAG_W-1:0] ret_tag;
  logic [N_WAY-1:0]       ret_told_valid;
  logic [N_WAY*TAG_W-1:0] ret_told;
  logic                   flush;
  logic [XLEN-1:0]        flush_pc;
  logic [N_ROB-1:0]       squash_valid;
  logic [N_ROB*TAG_W-1:0] squash_tag;
  logic [5:0]             free_slots;

  int vectors;
  int miscompares;

  rob_ring dut (
    .clock          (clock),
    .reset          (reset),
    .dis_valid      (dis_valid),
    .dis_tag        (dis_tag),
    .dis_told       (dis_told),
    .dis_branch     (dis_branch),
    .dis_ready      (dis_ready),
    .cmp_valid      (cmp_valid),
    .cmp_tag        (cmp_tag),
    .cmp_mispred    (cmp_mispred),
    .cmp_target     (cmp_target),
    .ret_valid      (ret_valid),
    .ret_tag        (ret_tag),
    .ret_told_valid (ret_told_valid),
    .ret_told       (ret_told),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .squash_valid   (squash_valid),
    .squash_tag     (squash_tag),
    .free_slots     (free_slots)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_dis(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] o0,
                         input logic [5:0] t1, input logic [5:0] o1, input logic [1:0] br);
    dis_valid  = v;
    dis_tag    = {t1, t0};
    dis_told   = {o1, o0};
    dis_branch = br;
  endtask

  task automatic set_cmp(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                         input logic [1:0] mp, input logic [31:0] tgt0);
    cmp_valid   = v;
    cmp_tag     = {t1, t0};
    cmp_mispred = mp;
    cmp_target  = {32'h0, tgt0};
  endtask

  task automatic idle();
    set_dis(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    set_cmp(2'b00, 6'd0, 6'd0, 2'b00, 32'h0);
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    @(negedge clock);
    #1;
    if (free_slots !== 6'd32) begin $display("FAIL reset_free_slots: got %0d expected 32", free_slots); miscompares++; end
    vectors++;
    if (ret_valid !== 2'b00 || flush !== 1'b0 || flush_pc !== 32'h0) begin
      $display("FAIL reset_outputs: ret_valid=%b flush=%b flush_pc=%h expected 00/0/0", ret_valid, flush, flush_pc);
      miscompares++;
    end
    vectors++;
    if (squash_valid !== '0 || dis_ready !== 2'b00) begin
      $display("FAIL reset_squash: squash_valid=%h dis_ready=%b expected 0/00", squash_valid, dis_ready);
      miscompares++;
    end
    vectors++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_in_order_retire();
    set_dis(2'b11, 6'd1, 6'd0, 6'd2, 6'd5, 2'b00);
    #1;
    if (dis_ready !== 2'b11) begin $display("FAIL order_dis_ready: got %b expected 11", dis_ready); miscompares++; end
    vectors++;
    step();
    idle();
    set_cmp(2'b01, 6'd2, 6'd0, 2'b00, 32'h0);
    #1;
    if (free_slots !== 6'd30) begin $display("FAIL order_free_slots: got %0d expected 30", free_slots); miscompares++; end
    vectors++;
    if (ret_valid !== 2'b00) begin $display("FAIL order_no_retire_0: got %b expected 00", ret_valid); miscompares++; end
    vectors++;
    step();
    set_cmp(2'b01, 6'd1, 6'd0, 2'b00, 32'h0);
    #1;
    if (ret_valid !== 2'b00) begin $display("FAIL order_no_retire_1: got %b expected 00", ret_valid); miscompares++; end
    vectors++;
    step();
    idle();
    #1;
    if (ret_valid !== 2'b11) begin $display("FAIL order_ret_valid: got %b expected 11", ret_valid); miscompares++; end
    vectors++;
    if (ret_tag !== {6'd2, 6'd1}) begin $display("FAIL order_ret_tag: got %h expected %h", ret_tag, {6'd2, 6'd1}); miscompares++; end
    vectors++;
    // Lane 0 has told 0 (x0, not freeable); lane 1 has told 5.
    if (ret_told_valid !== 2'b10) begin $display("FAIL order_told_valid: got %b expected 10", ret_told_valid); miscompares++; end
    vectors++;
    if (ret_told[TAG_W +: TAG_W] !== 6'd5) begin $display("FAIL order_told: got %0d expected 5", ret_told[TAG_W +: TAG_W]); miscompares++; end
    vectors++;
    step();
    #1;
    if (free_slots !== 6'd32) begin $display("FAIL order_drained: got %0d expected 32", free_slots); miscompares++; end
    vectors++;
  endtask

  task automatic test_full_and_hold();
    for (int i = 0; i < 16; i++) begin
      set_dis(2'b11, 6'(2*i+1), 6'd0, 6'(2*i+2), 6'd0, 2'b00);
      #1;
      if (dis_ready !== 2'b11) begin $display("FAIL fill_dis_ready[%0d]: got %b expected 11", i, dis_ready); miscompares++; end
      vectors++;
      step();
    end
    set_dis(2'b11, 6'd33, 6'd0, 6'd34, 6'd0, 2'b00);
    set_cmp(2'b11, 6'd1, 6'd2, 2'b00, 32'h0);
    #1;
    if (free_slots !== 6'd0) begin $display("FAIL full_free_slots: got %0d expected 0", free_slots); miscompares++; end
    vectors++;
    if (dis_ready !== 2'b00) begin $display("FAIL full_dis_ready: got %b expected 00", dis_ready); miscompares++; end
    vectors++;
    step();
    set_cmp(2'b00, 6'd0, 6'd0, 2'b00, 32'h0);
    #1;
    if (ret_valid !== 2'b11) begin $display("FAIL hold_ret_valid: got %b expected 11", ret_valid); miscompares++; end
    vectors++;
    if (dis_ready !== 2'b00) begin $display("FAIL hold_dis_ready: got %b expected 00", dis_ready); miscompares++; end
    vectors++;
    step();
    #1;
    if (free_slots !== 6'd2) begin $display("FAIL hold_free_slots: got %0d expected 2", free_slots); miscompares++; end
    vectors++;
    if (dis_ready !== 2'b11) begin $display("FAIL hold_accept: got %b expected 11", dis_ready); miscompares++; end
    vectors++;
    step();
    idle();
    #1;
    if (free_slots !== 6'd0) begin $display("FAIL refull_free_slots: got %0d expected 0", free_slots); miscompares++; end
    vectors++;
  endtask

  task automatic test_wrap();
    do_reset();
    // Walk head and tail to slot 31: 15 pairs then one single entry.
    for (int i = 0; i < 15; i++) begin
      set_dis(2'b11, 6'd1, 6'd0, 6'd2, 6'd0, 2'b00);
      step();
      idle();
      set_cmp(2'b11, 6'd1, 6'd2, 2'b00, 32'h0);
      step();
      idle();
      #1;
      if (ret_valid !== 2'b11) begin $display("FAIL walk_ret_valid[%0d]: got %b expected 11", i, ret_valid); miscompares++; end
      vectors++;
      step();
    end
    set_dis(2'b01, 6'd1, 6'd0, 6'd0, 6'd0, 2'b00);
    step();
    idle();
    set_cmp(2'b01, 6'd1, 6'd0, 2'b00, 32'h0);
    step();
    idle();
    #1;
    if (ret_valid !== 2'b01) begin $display("FAIL walk_single: got %b expected 01", ret_valid); miscompares++; end
    vectors++;
    step();
    set_dis(2'b11, 6'd3, 6'd0, 6'd4, 6'd0, 2'b00);
    #1;
    if (dis_ready !== 2'b11 || free_slots !== 6'd32) begin
      $display("FAIL wrap_dispatch: dis_ready=%b free_slots=%0d expected 11/32", dis_ready, free_slots);
      miscompares++;
    end
    vectors++;
    step();
    idle();
    set_cmp(2'b11, 6'd3, 6'd4, 2'b00, 32'h0);
    step();
    idle();
    #1;
    if (ret_valid !== 2'b11) begin $display("FAIL wrap_ret_valid: got %b expected 11", ret_valid); miscompares++; end
    vectors++;
    if (ret_tag !== {6'd4, 6'd3}) begin $display("FAIL wrap_ret_tag: got %h expected %h", ret_tag, {6'd4, 6'd3}); miscompares++; end
    vectors++;
    if (free_slots !== 6'd30) begin $display("FAIL wrap_count: got %0d expected 30", free_slots); miscompares++; end
    vectors++;
    step();
    #1;
    if (free_slots !== 6'd32) begin $display("FAIL wrap_drained: got %0d expected 32", free_slots); miscompares++; end
    vectors++;
  endtask

  task automatic test_mispredict();
    // Head is slot 1: tag 7 -> slot 1, 8 -> 2, 9 -> 3, 10 -> 4.
    set_dis(2'b11, 6'd7, 6'd0, 6'd8, 6'd0, 2'b01);
    step();
    set_dis(2'b11, 6'd9, 6'd0, 6'd10, 6'd0, 2'b00);
    step();
    idle();
    set_cmp(2'b01, 6'd7, 6'd0, 2'b01, 32'h400);
    #1;
    if (flush !== 1'b0 || ret_valid !== 2'b00) begin
      $display("FAIL mp_before: flush=%b ret_valid=%b expected 0/00", flush, ret_valid);
      miscompares++;
    end
    vectors++;
    step();
    set_dis(2'b11, 6'd20, 6'd0, 6'd21, 6'd0, 2'b00);
    set_cmp(2'b01, 6'd9, 6'd0, 2'b00, 32'h0);
    #1;
    if (flush !== 1'b1 || flush_pc !== 32'h400) begin
      $display("FAIL mp_flush: flush=%b flush_pc=%h expected 1/00000400", flush, flush_pc);
      miscompares++;
    end
    vectors++;
    if (ret_valid !== 2'b01 || ret_tag[0 +: TAG_W] !== 6'd7) begin
      $display("FAIL mp_retire: ret_valid=%b tag=%0d expected 01/7", ret_valid, ret_tag[0 +: TAG_W]);
      miscompares++;
    end
    vectors++;
    if (squash_valid !== 32'h0000_001C) begin $display("FAIL mp_squash_valid: got %h expected 0000001c", squash_valid); miscompares++; end
    vectors++;
    if (squash_tag[2*TAG_W +: TAG_W] !== 6'd8 || squash_tag[3*TAG_W +: TAG_W] !== 6'd9 ||
        squash_tag[4*TAG_W +: TAG_W] !== 6'd10) begin
      $display("FAIL mp_squash_tag: got %0d,%0d,%0d expected 8,9,10", squash_tag[2*TAG_W +: TAG_W],
               squash_tag[3*TAG_W +: TAG_W], squash_tag[4*TAG_W +: TAG_W]);
      miscompares++;
    end
    vectors++;
    if (dis_ready !== 2'b00 || free_slots !== 6'd28) begin
      $display("FAIL mp_dis_blocked: dis_ready=%b free_slots=%0d expected 00/28", dis_ready, free_slots);
      miscompares++;
    end
    vectors++;
    step();
    idle();
    #1;
    if (free_slots !== 6'd32 || flush !== 1'b0 || ret_valid !== 2'b00 || squash_valid !== '0) begin
      $display("FAIL mp_after: free_slots=%0d flush=%b ret_valid=%b squash=%h expected 32/0/00/0",
               free_slots, flush, ret_valid, squash_valid);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      set_dis(2'b11, 6'(11+2*i), 6'd3, 6'(12+2*i), 6'd4, 2'b00);
      step();
    end
    idle();
    set_cmp(2'b11, 6'd11, 6'd12, 2'b00, 32'h0);
    step();
    idle();
    #1;
    if (ret_valid !== 2'b11 || free_slots !== 6'd22) begin
      $display("FAIL mid_live: ret_valid=%b free_slots=%0d expected 11/22", ret_valid, free_slots);
      miscompares++;
    end
    vectors++;
    reset = 1'b0;
    #1;
    if (ret_valid !== 2'b00 || ret_tag !== '0 || ret_told_valid !== 2'b00 || flush !== 1'b0) begin
      $display("FAIL mid_reset_ret: ret_valid=%b ret_tag=%h told_valid=%b flush=%b expected all 0",
               ret_valid, ret_tag, ret_told_valid, flush);
      miscompares++;
    end
    vectors++;
    if (free_slots !== 6'd32 || squash_valid !== '0) begin
      $display("FAIL mid_reset_count: free_slots=%0d squash=%h expected 32/0", free_slots, squash_valid);
      miscompares++;
    end
    vectors++;
    @(negedge clock);
    reset = 1'b1;
    step();
    #1;
    if (ret_valid !== 2'b00 || free_slots !== 6'd32) begin
      $display("FAIL mid_after: ret_valid=%b free_slots=%0d expected 00/32", ret_valid, free_slots);
      miscompares++;
    end
    vectors++;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_in_order_retire();
    test_full_and_hold();
    test_wrap();
    test_mispredict();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
